// File: rtl/rxdata_pkg.sv
// Shared definitions for the hex-word UART receiver: ASCII constants,
// receiver and parser state encodings, and the hex digit decoder.
package rxdata_pkg;

  localparam logic [7:0] CHR_0    = 8'h30;
  localparam logic [7:0] CHR_9    = 8'h39;
  localparam logic [7:0] CHR_X    = 8'h78;
  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_A_LO = 8'h61;
  localparam logic [7:0] CHR_F_LO = 8'h66;
  localparam logic [7:0] CHR_A_UP = 8'h41;
  localparam logic [7:0] CHR_F_UP = 8'h46;

  // Byte receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Word parser states
  typedef enum logic [2:0] {
    P_IDLE,
    P_X,
    P_HEX,
    P_CR,
    P_LF
  } p_state_t;

  // Returns {valid, nibble}; valid is 0 for anything that is not a hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0_0000;
    if (c >= CHR_0 && c <= CHR_9) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= CHR_A_LO && c <= CHR_F_LO) || (c >= CHR_A_UP && c <= CHR_F_UP)) begin
      // 'a'/'A' have low nibble 1, so adding 9 maps a..f onto 10..15
      r = {1'b1, 4'(c[3:0] + 4'd9)};
    end
    return r;
  endfunction

  // Where the parser lands after an unexpected byte: a '0' may begin a new word.
  function automatic p_state_t resync(input logic [7:0] c);
    return (c == CHR_0) ? P_X : P_IDLE;
  endfunction

endpackage

// File: rtl/rxdata_rxuart.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer, half-bit start
// validation and stop-bit framing check. The line must be seen high before
// the receiver arms, which covers both reset release and break conditions.
module rxuart
  import rxdata_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLOCKS_PER_BAUD - 1);

  logic            meta_q;
  logic            sync_q;
  logic [1:0]      fill_q;
  logic            armed_q;
  rx_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            wr_q;
  logic [7:0]      data_q;
  logic            ferr_q;

  // Two-flop synchronizer; fill_q marks when sync_q reflects the real line
  // rather than its reset value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      fill_q <= 2'b00;
    end else begin
      meta_q <= i_uart_rx;
      sync_q <= meta_q;
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Receiver FSM with baud counter and registered byte/error pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= RX_IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!armed_q) begin
            if (fill_q[1] && sync_q) armed_q <= 1'b1;
          end else if (!sync_q) begin
            state_q <= RX_START;
            cnt_q   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (cnt_q == '0) begin
            if (!sync_q) begin
              state_q <= RX_DATA;
              cnt_q   <= FULL_RELOAD;
              bit_q   <= '0;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {sync_q, shift_q[7:1]};
            cnt_q   <= FULL_RELOAD;
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == '0) begin
            if (sync_q) begin
              wr_q   <= 1'b1;
              data_q <= shift_q;
            end else begin
              ferr_q  <= 1'b1;
              armed_q <= 1'b0;
            end
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign o_wr        = wr_q;
  assign o_data      = data_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/rxdata.sv
// Receives "0x" + 8 hex digits + CR LF over UART and presents the 32-bit word
// with a one-cycle strobe; malformed input or framing errors raise o_err.
module rxdata
  import rxdata_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_uart_rx,
  output logic        o_stb,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic        rx_wr;
  logic [7:0]  rx_byte;
  logic        rx_ferr;
  logic [4:0]  hex;

  p_state_t    pst_q;
  logic [3:0]  cnt_q;
  logic [31:0] shadow_q;
  logic        stb_q;
  logic        err_q;
  logic [31:0] data_q;

  rxuart #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_rxuart (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_uart_rx  (i_uart_rx),
    .o_wr       (rx_wr),
    .o_data     (rx_byte),
    .o_frame_err(rx_ferr)
  );

  assign hex = hex_decode(rx_byte);

  // Word parser; a framing error overrides everything and discards the word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pst_q    <= P_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      stb_q <= 1'b0;
      err_q <= 1'b0;
      if (rx_ferr) begin
        err_q    <= 1'b1;
        pst_q    <= P_IDLE;
        shadow_q <= '0;
      end else if (rx_wr) begin
        case (pst_q)
          P_IDLE: begin
            if (rx_byte == CHR_0) pst_q <= P_X;
          end
          P_X: begin
            if (rx_byte == CHR_X) begin
              pst_q    <= P_HEX;
              cnt_q    <= '0;
              shadow_q <= '0;
            end else begin
              err_q <= 1'b1;
              pst_q <= P_IDLE;
            end
          end
          P_HEX: begin
            if (hex[4]) begin
              shadow_q <= {shadow_q[27:0], hex[3:0]};
              if (cnt_q == 4'd7) pst_q <= P_CR;
              else               cnt_q <= cnt_q + 4'd1;
            end else begin
              err_q <= 1'b1;
              pst_q <= resync(rx_byte);
            end
          end
          P_CR: begin
            if (rx_byte == CHR_CR) begin
              pst_q <= P_LF;
            end else begin
              err_q <= 1'b1;
              pst_q <= resync(rx_byte);
            end
          end
          P_LF: begin
            if (rx_byte == CHR_LF) begin
              stb_q  <= 1'b1;
              data_q <= shadow_q;
              pst_q  <= P_IDLE;
            end else begin
              err_q <= 1'b1;
              pst_q <= resync(rx_byte);
            end
          end
          default: pst_q <= P_IDLE;
        endcase
      end
    end
  end

  assign o_stb  = stb_q;
  assign o_err  = err_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_rxdata.sv
// Directed scoreboard bench for rxdata at 16 clocks per baud.
module tb_rxdata;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        stb;
  logic        err;
  logic [31:0] data;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          stb_cnt  = 0;
  int          err_cnt  = 0;
  logic        both_hi  = 1'b0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rxdata #(.CLOCKS_PER_BAUD(CPB)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_uart_rx(rx),
    .o_stb    (stb),
    .o_data   (data),
    .o_err    (err)
  );

  // Output monitor: records strobes, errors and delivered words.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stb === 1'b1) begin
        stb_cnt <= stb_cnt + 1;
        obs_q.push_back(data);
      end
      if (err === 1'b1) err_cnt <= err_cnt + 1;
      if (stb === 1'b1 && err === 1'b1) both_hi <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_word(input string s, input logic [31:0] w);
    exp_q.push_back(w);
    send_str(s);
  endtask

  // Compares strobe/error counts since the bases and drains the scoreboard.
  task automatic check_group(input string tag, input int base_s, input int base_e,
                             input int n_s, input int n_e);
    logic [31:0] o;
    logic [31:0] e;
    idle(2 * CPB);
    check({tag, "_stb_count"}, 32'(stb_cnt - base_s), 32'(n_s));
    check({tag, "_err_count"}, 32'(err_cnt - base_e), 32'(n_e));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_word"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int bs;
    int be;
    rx    = 1'b1;
    rst_n = 1'b0;
    idle(4);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", data, 32'h0);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_stb", {31'd0, stb}, 32'd0);
    check("post_rst_err", {31'd0, err}, 32'd0);
    idle(2 * CPB);

    // Single well-formed word, upper-case hex
    bs = stb_cnt; be = err_cnt;
    send_word("0x1234ABCD\r\n", 32'h1234ABCD);
    check_group("word1", bs, be, 1, 0);

    // Two back-to-back words, lower-case hex and small value
    bs = stb_cnt; be = err_cnt;
    send_word("0xdeadbeef\r\n", 32'hDEADBEEF);
    send_word("0x00000001\r\n", 32'h00000001);
    check_group("word2", bs, be, 2, 0);

    // Bad digit: one error, no strobe, previous word held
    bs = stb_cnt; be = err_cnt;
    send_str("0x12G4\r\n");
    check_group("baddigit", bs, be, 0, 1);
    check("baddigit_hold", data, 32'h00000001);

    // Framing error then recovery with an all-ones word
    bs = stb_cnt; be = err_cnt;
    send_byte(8'h30, 1'b0);
    send_word("0xFFFFFFFF\r\n", 32'hFFFFFFFF);
    check_group("frame", bs, be, 1, 1);

    // Short low glitch on the idle line
    bs = stb_cnt; be = err_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    check_group("glitch", bs, be, 0, 0);

    // Reset in the middle of the fifth hex digit
    bs = stb_cnt; be = err_cnt;
    send_str("0x1234");
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(CPB / 2);
    rst_n = 1'b0;
    idle(3);
    check("midrst_stb", {31'd0, stb}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_data", data, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("midrel_stb", {31'd0, stb}, 32'd0);
    check("midrel_err", {31'd0, err}, 32'd0);
    idle(2 * CPB);
    send_word("0x0000CAFE\r\n", 32'h0000CAFE);
    check_group("midrst", bs, be, 1, 0);
    check("midrst_final", data, 32'h0000CAFE);

    check("stb_err_exclusive", {31'd0, both_hi}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
